// File: rtl/bitonic_pkg.sv
// Shared constants for the 8-lane bitonic sorter stages.
package bitonic_pkg;
  localparam int   LANES    = 8;
  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;
endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-exchange: ASC puts the min on lo, DESC puts the max on lo.
module bitonic_cas
  import bitonic_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic DIR   = DIR_ASC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  // Strict compares so equal values pass straight through.
  assign swap = (DIR == DIR_ASC) ? (a > b) : (a < b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_s2_pipe.sv
// Bitonic sorter stage 2: two registered compare-exchange layers with valid/ready flow.
module bitonic_s2_pipe
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  logic [LANES*WIDTH-1:0] a_data;
  logic [LANES*WIDTH-1:0] l1_data;
  logic [LANES*WIDTH-1:0] l2_data;
  logic                   a_valid;
  logic                   a_ready;
  logic                   in_fire;
  logic                   out_fire;

  logic [WIDTH-1:0] in_lanes [LANES];
  logic [WIDTH-1:0] l1_lanes [LANES];
  logic [WIDTH-1:0] a_lanes  [LANES];
  logic [WIDTH-1:0] l2_lanes [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lanes
    assign in_lanes[k]              = in_data[k*WIDTH +: WIDTH];
    assign a_lanes[k]               = a_data[k*WIDTH +: WIDTH];
    assign l1_data[k*WIDTH +: WIDTH] = l1_lanes[k];
    assign l2_data[k*WIDTH +: WIDTH] = l2_lanes[k];
  end

  // Comparators 0-1 serve the ascending half (lanes 1-4), 2-3 the descending half.
  for (genvar i = 0; i < 4; i++) begin : g_cas
    localparam logic DIR   = (i < 2) ? DIR_ASC : DIR_DESC;
    localparam int   L1_LO = (i / 2) * 4 + (i % 2);
    localparam int   L2_LO = i * 2;

    bitonic_cas #(.WIDTH(WIDTH), .DIR(DIR)) u_l1 (
      .a  (in_lanes[L1_LO]),
      .b  (in_lanes[L1_LO+2]),
      .lo (l1_lanes[L1_LO]),
      .hi (l1_lanes[L1_LO+2])
    );

    bitonic_cas #(.WIDTH(WIDTH), .DIR(DIR)) u_l2 (
      .a  (a_lanes[L2_LO]),
      .b  (a_lanes[L2_LO+1]),
      .lo (l2_lanes[L2_LO]),
      .hi (l2_lanes[L2_LO+1])
    );
  end

  assign out_fire = out_valid & out_ready;
  assign a_ready  = !out_valid | out_ready;
  assign in_ready = !a_valid | a_ready;
  assign in_fire  = in_valid & in_ready;
  assign busy     = a_valid | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_data    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_fire) begin
        a_data  <= l1_data;
        a_valid <= 1'b1;
      end else if (a_valid && a_ready) begin
        a_valid <= 1'b0;
      end

      if (a_valid && a_ready) begin
        out_data  <= l2_data;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_s2_pipe.sv
// Self-checking bench for bitonic_s2_pipe: directed vector table, flow-control corners, random scoreboard.
module tb_bitonic_s2_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int in_count  = 0;
  int out_count = 0;
  int first_out = -1;
  int last_out  = -1;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data = '0;
  logic [63:0] exp_q [$];

  typedef struct {
    logic [63:0] vin;
    logic [63:0] vexp;
  } vec_t;

  bitonic_s2_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack8(input int l1, input int l2, input int l3, input int l4,
                                        input int l5, input int l6, input int l7, input int l8);
    return {8'(l8), 8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1)};
  endfunction

  // Expected stage-2 result for a well-formed stage-1 vector: lanes 1-4 sorted up, 5-8 sorted down.
  function automatic logic [63:0] ref_model(input logic [63:0] v);
    int l [8];
    int t;
    logic [63:0] r;
    for (int k = 0; k < 8; k++) l[k] = int'(v[k*8 +: 8]);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3 - p; k++) begin
        if (l[k] > l[k+1]) begin t = l[k]; l[k] = l[k+1]; l[k+1] = t; end
        if (l[k+4] < l[k+5]) begin t = l[k+4]; l[k+4] = l[k+5]; l[k+5] = t; end
      end
    end
    r = '0;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(l[k]);
    return r;
  endfunction

  // Random stage-1 vector: pairs (1,2),(5,6) ascending, (3,4),(7,8) descending.
  function automatic logic [63:0] gen_stage1();
    logic [63:0] r;
    int a;
    int b;
    int t;
    int hi_val;
    hi_val = ($urandom_range(0, 3) == 0) ? 3 : 255;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      a = int'($urandom_range(0, hi_val));
      b = int'($urandom_range(0, hi_val));
      if (((p % 2) == 0 && a > b) || ((p % 2) == 1 && a < b)) begin
        t = a; a = b; b = t;
      end
      r[p*16 +: 8]     = 8'(a);
      r[p*16 + 8 +: 8] = 8'(b);
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of input; report whether the handshake completed at the coming edge.
  task automatic apply_stimulus(input logic v, input logic [63:0] d, output logic fired);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    fired = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check_output({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check_output({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data));
        in_count++;
      end
      if (stall_prev) begin
        check_output("stall_valid", 64'(out_valid), 64'd1);
        check_output("stall_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_out", out_data, 64'hx);
        end else begin
          check_output("out_data", out_data, exp_q.pop_front());
        end
        out_count++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial begin
    vec_t        tbl [5];
    logic        fired;
    logic [63:0] bp [3];
    logic [63:0] sv;
    int          idx;
    int          stalls;
    int          budget;
    int          seen;
    int          base_out;

    tbl[0] = '{pack8(10, 40, 30, 20, 50, 80, 70, 60), pack8(10, 20, 30, 40, 80, 70, 60, 50)};
    tbl[1] = '{pack8(5, 5, 5, 5, 9, 9, 9, 9),         pack8(5, 5, 5, 5, 9, 9, 9, 9)};
    tbl[2] = '{pack8(3, 7, 7, 3, 1, 4, 4, 1),         pack8(3, 3, 7, 7, 4, 4, 1, 1)};
    tbl[3] = '{pack8(0, 255, 255, 0, 0, 255, 255, 0), pack8(0, 0, 255, 255, 255, 255, 0, 0)};
    tbl[4] = '{pack8(127, 200, 128, 1, 128, 200, 127, 1), pack8(1, 127, 128, 200, 200, 128, 127, 1)};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_out_data", out_data, 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: single vectors with exact latency and one-cycle out_valid.
    $display("[TB] directed vectors");
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, tbl[i].vin, fired);
      in_valid = 1'b0;
      check_output("tbl_accept", 64'(fired), 64'd1);
      check_output("tbl_lat1_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check_output("tbl_lat2_valid", 64'(out_valid), 64'd1);
      check_output("tbl_data", out_data, tbl[i].vexp);
      @(posedge clk);
      #1;
      check_output("tbl_one_cycle", 64'(out_valid), 64'd0);
    end

    // Back-to-back stream of 16 vectors with the sink always ready.
    $display("[TB] stream");
    first_out = -1;
    base_out  = out_count;
    stalls    = 0;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, gen_stage1(), fired);
      if (!fired) stalls++;
    end
    drain("stream");
    check_output("stream_stalls", 64'(stalls), 64'd0);
    check_output("stream_count", 64'(out_count - base_out), 64'd16);
    check_output("stream_span", 64'(last_out - first_out + 1), 64'd16);

    // Backpressure: three vectors offered while the sink stalls for five cycles.
    $display("[TB] backpressure");
    bp[0] = tbl[0].vin;
    bp[1] = tbl[2].vin;
    bp[2] = tbl[4].vin;
    base_out  = out_count;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(idx < 3, bp[idx % 3], fired);
      if (fired) idx++;
    end
    check_output("bp_accepts", 64'(idx), 64'd2);
    check_output("bp_in_ready", 64'(in_ready), 64'd0);
    check_output("bp_out_valid", 64'(out_valid), 64'd1);
    check_output("bp_out_data", out_data, tbl[0].vexp);
    check_output("bp_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    budget = 0;
    while (idx < 3 && budget < 20) begin
      apply_stimulus(1'b1, bp[idx], fired);
      if (fired) idx++;
      budget++;
    end
    check_output("bp_third_accept", 64'(idx), 64'd3);
    drain("bp");
    check_output("bp_count", 64'(out_count - base_out), 64'd3);

    // Asynchronous reset with two vectors in flight.
    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    apply_stimulus(1'b1, gen_stage1(), fired);
    apply_stimulus(1'b1, gen_stage1(), fired);
    in_valid = 1'b0;
    check_output("rst_pre_busy", 64'(busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_data", out_data, 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_output("rst_no_emit", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    $display("[TB] random");
    base_out = out_count;
    idx = 0;
    budget = 0;
    while (idx < 10000 && budget < 60000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      sv = gen_stage1();
      apply_stimulus($urandom_range(0, 9) < 7, sv, fired);
      if (fired) idx++;
      budget++;
    end
    check_output("rand_sent", 64'(idx), 64'd10000);
    drain("rand");
    check_output("rand_count", 64'(out_count - base_out), 64'(idx));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
